// File: rtl/aoi_vector_finder_if.sv
// aoi_vector_finder_if: start/result/vector-stream bundle for the inverse cell evaluator
interface aoi_vector_finder_if;
  logic start;
  logic target;
  logic vec_ready;
  logic busy;
  logic vec_valid;
  logic [2:0] vec;
  logic done;
  logic [3:0] match_count;
  modport master (
    output start, target, vec_ready,
    input  busy, vec_valid, vec, done, match_count
  );
  modport slave (
    input  start, target, vec_ready,
    output busy, vec_valid, vec, done, match_count
  );
endinterface

// File: rtl/aoi_vector_finder.sv
// aoi_vector_finder: walks {A,B,C} in ascending order and streams every vector whose
// cell output equals the requested target, then pulses done with the match count.
module aoi_vector_finder #(
  parameter logic [7:0] TRUTH = 8'b0001_0101
) (
  input logic clk,
  input logic rst_n,
  aoi_vector_finder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] idx;
  logic [2:0] vec_q;
  logic [3:0] cnt;
  logic tgt_q;
  logic hit;
  logic last;
  logic hs;
  assign hit  = TRUTH[idx] == tgt_q;
  assign last = idx == 3'd7;
  assign hs   = state == EMIT && bus.vec_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? SCAN : IDLE;
      SCAN:    state_nx = hit ? EMIT : (last ? DONE : SCAN);
      EMIT:    state_nx = !bus.vec_ready ? EMIT : (last ? DONE : SCAN);
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.busy        = state != IDLE;
    bus.vec_valid   = state == EMIT;
    bus.done        = state == DONE;
    bus.vec         = vec_q;
    bus.match_count = cnt;
  end
  // idx stops at 7 so the search can never wrap and re-emit a vector
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx   <= 3'd0;
      vec_q <= 3'd0;
      cnt   <= 4'd0;
      tgt_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        tgt_q <= bus.target;
        idx   <= 3'd0;
        cnt   <= 4'd0;
      end
      if (state == SCAN && hit) vec_q <= idx;
      if (((state == SCAN && !hit) || hs) && !last) idx <= idx + 3'd1;
      if (hs) cnt <= cnt + 4'd1;
    end
endmodule
